// File: rtl/text_term_pkg.sv
// Shared constants and FSM encoding for the text-mode video memory.
package text_term_pkg;

    localparam logic [7:0] ASCII_ENTER = 8'd10;
    localparam logic [7:0] ASCII_BS    = 8'd8;

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        CLR_ROW
    } state_t;

endpackage

// File: rtl/text_term_ram.sv
// Character cell store: one synchronous write port, one registered read port (read-before-write).
module text_term_ram #(
    parameter int unsigned DEPTH = 2100,
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/text_term_vmem.sv
// Text-mode video memory: keyboard-side cursor/scroll control and VGA-side cell/glyph lookup.
module text_term_vmem
    import text_term_pkg::*;
#(
    parameter  int unsigned COLS         = 70,
    parameter  int unsigned ROWS         = 30,
    parameter  int unsigned CHAR_W       = 9,
    parameter  int unsigned CHAR_H       = 16,
    parameter  int unsigned BLINK_CYCLES = 12500000,
    localparam int unsigned XW           = $clog2(COLS),
    localparam int unsigned YW           = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_char,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [9:0]    h_addr,
    input  logic [9:0]    v_addr,
    output logic [7:0]    ascii_out,
    output logic [3:0]    row,
    output logic [3:0]    col,
    output logic          cursor_hit,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y
);

    localparam int unsigned DEPTH = COLS * ROWS;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned YE    = YW + 1;
    localparam int unsigned BW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    state_t        r_state;
    logic          r_ready;
    logic [XW-1:0] r_cur_x;
    logic [YW-1:0] r_cur_y;
    logic [YW-1:0] r_top;
    logic [YW-1:0] r_clr_prow;
    logic [AW-1:0] r_cnt;
    logic [BW-1:0] r_bcnt;
    logic          r_blink;
    logic          r_rd_ok;
    logic [3:0]    r_row;
    logic [3:0]    r_col;
    logic          r_hit;

    logic          w_accept;
    logic          w_nl;
    logic          w_bs;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_wdata;
    logic          w_rd_ok;
    logic [AW-1:0] w_raddr;
    logic [7:0]    w_rdata;

    // Logical row -> physical row through the circular top offset, then linear address.
    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] ly,
                                                input logic [YW-1:0] top,
                                                input logic [XW-1:0] cx);
        logic [YW:0] prow;
        prow = {1'b0, ly} + {1'b0, top};
        if (prow >= YE'(ROWS)) begin
            prow = prow - YE'(ROWS);
        end
        return AW'(prow) * AW'(COLS) + AW'(cx);
    endfunction

    assign w_rd_ok = (32'(x) < COLS) && (32'(y) < ROWS);
    assign w_raddr = w_rd_ok ? cell_addr(y, r_top, x) : '0;

    // Single write port shared by bulk clear, row clear and keyboard edits.
    always_comb begin
        w_we     = 1'b0;
        w_waddr  = '0;
        w_wdata  = '0;
        w_accept = (r_state == IDLE) && in_valid;
        w_bs     = w_accept && (in_char == ASCII_BS);
        w_nl     = w_accept && ((in_char == ASCII_ENTER) ||
                   ((in_char != ASCII_BS) && (r_cur_x == XW'(COLS - 1))));
        case (r_state)
            CLR_ALL: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
            end
            CLR_ROW: begin
                w_we    = 1'b1;
                w_waddr = cell_addr(r_clr_prow, '0, XW'(r_cnt));
            end
            default: begin
                if (w_bs) begin
                    if (r_cur_x != '0) begin
                        w_we    = 1'b1;
                        w_waddr = cell_addr(r_cur_y, r_top, r_cur_x - XW'(1));
                    end else if (r_cur_y != '0) begin
                        w_we    = 1'b1;
                        w_waddr = cell_addr(r_cur_y - YW'(1), r_top, XW'(COLS - 1));
                    end
                end else if (w_accept && (in_char != ASCII_ENTER)) begin
                    w_we    = 1'b1;
                    w_waddr = cell_addr(r_cur_y, r_top, r_cur_x);
                    w_wdata = in_char;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= CLR_ALL;
            r_ready    <= 1'b0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_top      <= '0;
            r_clr_prow <= '0;
            r_cnt      <= '0;
            r_bcnt     <= '0;
            r_blink    <= 1'b0;
            r_rd_ok    <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_hit      <= 1'b0;
        end else begin
            if (r_bcnt == BW'(BLINK_CYCLES - 1)) begin
                r_bcnt  <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
            end

            r_rd_ok <= w_rd_ok;
            r_row   <= 4'(v_addr - 10'(y) * 10'(CHAR_H));
            r_col   <= 4'(h_addr - 10'(x) * 10'(CHAR_W));
            r_hit   <= (r_state == IDLE) && r_blink && (x == r_cur_x) && (y == r_cur_y);

            case (r_state)
                CLR_ALL: begin
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                CLR_ROW: begin
                    if (r_cnt == AW'(COLS - 1)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                default: begin
                    if (w_nl) begin
                        r_cur_x <= '0;
                        if (r_cur_y != YW'(ROWS - 1)) begin
                            r_cur_y <= r_cur_y + YW'(1);
                        end else begin
                            // Scroll: the old top row becomes the new, blank bottom row.
                            r_top      <= (r_top == YW'(ROWS - 1)) ? '0 : r_top + YW'(1);
                            r_clr_prow <= r_top;
                            r_state    <= CLR_ROW;
                            r_ready    <= 1'b0;
                        end
                    end else if (w_bs) begin
                        if (r_cur_x != '0) begin
                            r_cur_x <= r_cur_x - XW'(1);
                        end else if (r_cur_y != '0) begin
                            r_cur_y <= r_cur_y - YW'(1);
                            r_cur_x <= XW'(COLS - 1);
                        end
                    end else if (w_accept) begin
                        r_cur_x <= r_cur_x + XW'(1);
                    end
                end
            endcase
        end
    end

    text_term_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (8)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign in_ready   = r_ready;
    assign ascii_out  = r_rd_ok ? w_rdata : 8'h00;
    assign row        = r_row;
    assign col        = r_col;
    assign cursor_hit = r_hit;
    assign cur_x      = r_cur_x;
    assign cur_y      = r_cur_y;

endmodule

// File: tb/tb_text_term_vmem.sv
// Randomized scoreboard bench for text_term_vmem against a scrolling-screen reference model.
module tb_text_term_vmem;

    localparam int COLS   = 70;
    localparam int ROWS   = 30;
    localparam int CHAR_W = 9;
    localparam int CHAR_H = 16;
    localparam int BLINK  = 4;
    localparam int XW     = $clog2(COLS);
    localparam int YW     = $clog2(ROWS);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_char;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [9:0]    h_addr;
    logic [9:0]    v_addr;
    logic [7:0]    ascii_out;
    logic [3:0]    row;
    logic [3:0]    col;
    logic          cursor_hit;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;

    text_term_vmem #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .CHAR_W       (CHAR_W),
        .CHAR_H       (CHAR_H),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .x          (x),
        .y          (y),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .ascii_out  (ascii_out),
        .row        (row),
        .col        (col),
        .cursor_hit (cursor_hit),
        .cur_x      (cur_x),
        .cur_y      (cur_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] a;
        logic [3:0] r;
        logic [3:0] c;
    } exp_t;

    exp_t       sb[$];
    logic       rd_req = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    // Reference screen: logical rows, scrolling by shifting rows up.
    logic [7:0] scr [ROWS][COLS];
    int         cx, cy;

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h00;
        cx = 0;
        cy = 0;
    endfunction

    function automatic void m_newline();
        cx = 0;
        if (cy < ROWS - 1) begin
            cy++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++)
                scr[ROWS-1][c] = 8'h00;
        end
    endfunction

    function automatic void m_apply(logic [7:0] ch);
        if (ch == 8'd10) begin
            m_newline();
        end else if (ch == 8'd8) begin
            if (cx > 0) begin
                cx--;
                scr[cy][cx] = 8'h00;
            end else if (cy > 0) begin
                cy--;
                cx = COLS - 1;
                scr[cy][cx] = 8'h00;
            end
        end else begin
            scr[cy][cx] = ch;
            if (cx == COLS - 1) m_newline();
            else cx++;
        end
    endfunction

    // Cycle count since reset release, for the blink phase.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) cyc = 0;
            else cyc++;
        end
    end

    // Monitor: one read response per requested read, one cycle later.
    initial begin
        logic due;
        exp_t e;
        forever begin
            @(posedge clk);
            due = rd_req;
            @(negedge clk);
            if (due) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("ascii(%0d,%0d)", e.x, e.y), int'(ascii_out), int'(e.a));
                    chk($sformatf("row(%0d,%0d)", e.x, e.y), int'(row), int'(e.r));
                    chk($sformatf("col(%0d,%0d)", e.x, e.y), int'(col), int'(e.c));
                end
            end
        end
    end

    task automatic rd(int xx, int yy, int hh, int vv);
        exp_t e;
        e.x = xx;
        e.y = yy;
        if (xx >= COLS || yy >= ROWS) e.a = 8'h00;
        else e.a = scr[yy][xx];
        e.r = 4'((vv - yy * CHAR_H) & 15);
        e.c = 4'((hh - xx * CHAR_W) & 15);
        x      = XW'(xx);
        y      = YW'(yy);
        h_addr = 10'(hh);
        v_addr = 10'(vv);
        sb.push_back(e);
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int yy = 0; yy < ROWS; yy++)
            for (int xx = 0; xx < COLS; xx++)
                rd(xx, yy, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    endtask

    task automatic send(logic [7:0] ch);
        int n = 0;
        while (!in_ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_char  = ch;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        m_apply(ch);
    endtask

    task automatic busy_cycles(int exp, string name);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cur(string name);
        chk({name, "_cur_x"}, int'(cur_x), cx);
        chk({name, "_cur_y"}, int'(cur_y), cy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_ascii", int'(ascii_out), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_col", int'(col), 0);
        chk("rst_cursor_hit", int'(cursor_hit), 0);
        chk("rst_cur_x", int'(cur_x), 0);
        chk("rst_cur_y", int'(cur_y), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_clear();
        busy_cycles(ROWS * COLS, "clr_all_busy");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        x        = '0;
        y        = '0;
        h_addr   = '0;
        v_addr   = '0;
        m_clear();

        // Power-up clear
        do_reset();
        chk_cur("init");
        read_all();

        // Single printable char and glyph column arithmetic
        send(8'h41);
        rd(0, 0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        rd(1, 0, 12, 0);
        chk_cur("after_A");

        // Line wrap then backspace across the line boundary
        for (int i = 0; i < COLS - 1; i++) send(8'($urandom_range(32, 126)));
        chk_cur("wrap");
        send(8'd8);
        chk_cur("bs_wrap");
        rd(COLS - 1, 0, 0, 0);
        rd(COLS - 2, 0, 0, 0);
        send(8'd8);
        send(8'd8);
        chk_cur("bs_more");

        // Scroll: row of 'B' moves to the top, bottom row blank
        do_reset();
        send(8'd8);
        chk_cur("bs_origin");
        send(8'd10);
        for (int i = 0; i < COLS; i++) send(8'h42);
        while (cy < ROWS - 1) send(8'd10);
        send(8'd10);
        busy_cycles(COLS, "clr_row_busy");
        chk_cur("scroll");
        read_all();

        // Random edits, scrolls and reads (including out-of-range cells)
        for (int i = 0; i < 700; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10) send(8'd8);
            else if (r < 16) send(8'd10);
            else if (r < 20) rd(int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                                int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            else send(8'($urandom_range(32, 126)));
        end
        chk_cur("random");
        read_all();
        rd(COLS, 0, 0, 0);
        rd(0, ROWS, 0, 0);
        rd(127, 31, 1023, 1023);

        // Reset in the middle of a row clear
        while (cy < ROWS - 1) send(8'd10);
        send(8'd10);
        repeat (10) @(posedge clk);
        #1;
        do_reset();
        chk_cur("mid_clr_reset");
        read_all();

        // Blink phase on the cursor cell, then off the cursor cell
        send(8'h43);
        send(8'h44);
        x = XW'(cx);
        y = YW'(cy);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk("cursor_hit_on_cell", int'(cursor_hit), ((cyc - 1) / BLINK) % 2);
        end
        @(posedge clk);
        #1;
        x = XW'(cx + 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("cursor_hit_off_cell", int'(cursor_hit), 0);
        end
        @(posedge clk);
        #1;
        rd(COLS, cy, 0, 0);
        rd(cx - 1, cy, 100, 200);
        @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
